mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
//  Multi-cycle signed 32x32 multiply sequencer (radix-2 Booth, 32 steps).
//  Owns no adder: drives the shared 32-bit add/sub unit (A, B, sub -> out, ovf) through a req/gnt port.
//  Sits beside the ALU in the execute stage. The pipeline issues ctrl_mult and stalls until data_resultRDY.
// PARAMETERS
//  (none) - width fixed at 32 to match the shared add/sub unit
// PORTS
//  clock           in   1   single clock, all state on rising edge
//  reset_n         in   1   synchronous, active-low reset
//  ctrl_mult       in   1   start pulse; samples data_operandA/B this cycle
//  data_operandA   in   32  multiplicand M (signed)
//  data_operandB   in   32  multiplier Q (signed)
//  data_result     out  32  low 32 bits of product, held until next start
//  data_exception  out  1   product does not fit in signed 32 bits
//  data_resultRDY  out  1   one-cycle pulse: result/exception valid
//  add_req         out  1   requests shared adder; high throughout RUN
//  add_gnt         in   1   adder granted this cycle; low = stall step
//  add_a           out  32  adder A = P[64:33] (current high half)
//  add_b           out  32  adder B = M
//  add_sub         out  1   1 = subtract (Booth pair 10), else add
//  add_out         in   32  adder sum, combinational same cycle
//  add_ovf         in   1   adder signed overflow, same cycle
// BEHAVIOUR
//  - Regs: M[31:0], P[64:0] = {hi[31:0], lo[31:0], q_m1}, cnt[4:0], state.
//  - Reset (reset_n=0 at edge): state=IDLE, M/P/cnt=0.
//    data_result=0, data_exception=0, data_resultRDY=0, add_req=0.
//  - IDLE: ctrl_mult=1 -> M<=A, P<={32'b0, B, 1'b0}, cnt<=0 -> RUN.
//  - RUN, add_gnt=1: pair = P[1:0].
//    01 -> add M; 10 -> subtract M; 00/11 -> no-op.
//    Adder used: s=add_out, sgn=add_out[31]^add_ovf (true sign, covers M=0x80000000).
//    No-op: s=P[64:33], sgn=P[64].
//    P <= {sgn, s, P[32:1]} (arithmetic shift right by 1); cnt++.
//    cnt==31 on a granted step -> DONE.
//  - RUN, add_gnt=0: P, cnt, state hold. add_req stays 1; add_a/add_b/add_sub still driven.
//  - DONE (1 cycle): data_result<=lo, data_exception<=(hi != {32{lo[31]}}), data_resultRDY=1 -> IDLE.
//  - Latency with gnt always high: ctrl_mult at cycle 0 -> RDY at cycle 33.
//    Each denied cycle adds 1.
//  - ctrl_mult in RUN or DONE: abort, restart with new operands. No RDY for the aborted op.
//  - data_result/data_exception change only in DONE or on reset.
//  - add_req=0 outside RUN; add_sub=0 when pair is 00/11.
// CONFIGURATION
//  MULT_SEQ_HI_EN defined: extra port data_result_hi out 32.
//    Loaded with hi in DONE, reset 0, held like data_result.
//  MULT_SEQ_HI_EN undefined: port absent, upper half discarded. Exception logic identical either way.
// TESTING
//  1. A=3, B=5, gnt=1 -> RDY at cycle 33, result=0x0000000F, exc=0.
//  2. A=0xFFFFFFF9 (-7), B=6 -> result=0xFFFFFFD6 (-42), exc=0.
//  3. A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exc=1.
//     Exercises add_ovf sign path; hi=0 with HI_EN.
//  4. A=0x00010000, B=0x00010000 -> result=0, exc=1; hi=0x00000001 with HI_EN.
//  5. Case 1 with gnt=0 on cycles 10-14 -> RDY at cycle 38, result=15, add_req high cycles 1-32+5.
//  6. reset_n=0 at cycle 12 of op -> IDLE, no RDY, outputs 0.
//     Then ctrl_mult A=2,B=-3 restarted mid-RUN of another op -> single RDY, result=0xFFFFFFFA.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// Radix-2 Booth 32x32 signed multiply sequencer driving a shared add/sub unit via req/gnt.
// Optional MULT_SEQ_HI_EN adds data_result_hi carrying the upper product half.
module mult_seq_ctrl (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ctrl_mult,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        add_req,
   input  logic        add_gnt,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   output logic        add_sub,
   input  logic [31:0] add_out,
   input  logic        add_ovf,
`ifdef MULT_SEQ_HI_EN
   output logic [31:0] data_result_hi,
`endif
   output logic [1:0]  state_dbg
);

   // Handshake: add_req stays high for every RUN cycle; a step (shift + count)
   // commits only on a cycle where add_gnt is high, otherwise everything holds.
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nx;
   logic [31:0] m;
   logic [64:0] p;
   logic [4:0]  cnt;
   logic [31:0] res_q;
   logic        exc_q;

   logic [1:0]  pair;
   logic        use_add;
   logic [31:0] hi, lo, s;
   logic        sgn, exc_now;

   assign pair    = p[1:0];
   assign hi      = p[64:33];
   assign lo      = p[32:1];
   assign use_add = (pair == 2'b01) || (pair == 2'b10);
   assign exc_now = (hi != {32{lo[31]}});

   assign add_a     = hi;
   assign add_b     = m;
   assign state_dbg = state;

   // The adder's raw MSB is wrong on overflow (M = 0x80000000); xor with ovf gives the true sign.
   always_comb begin
      s   = hi;
      sgn = p[64];
      if (use_add) begin
         s   = add_out;
         sgn = add_out[31] ^ add_ovf;
      end
   end

   always_comb begin
      state_nx       = state;
      add_req        = 1'b0;
      add_sub        = 1'b0;
      data_resultRDY = 1'b0;
      case (state)
         IDLE: begin
            if (ctrl_mult) state_nx = RUN;
         end
         RUN: begin
            add_req = 1'b1;
            add_sub = (pair == 2'b10);
            if (ctrl_mult)                       state_nx = RUN;
            else if (add_gnt && cnt == 5'd31)    state_nx = DONE;
         end
         DONE: begin
            if (ctrl_mult) begin
               state_nx = RUN;
            end else begin
               data_resultRDY = 1'b1;
               state_nx       = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         m     <= '0;
         p     <= '0;
         cnt   <= '0;
         res_q <= '0;
         exc_q <= 1'b0;
      end else begin
         if (ctrl_mult) begin
            m   <= data_operandA;
            p   <= {32'b0, data_operandB, 1'b0};
            cnt <= '0;
         end else if (state == RUN && add_gnt) begin
            p   <= {sgn, s, p[32:1]};
            cnt <= cnt + 5'd1;
         end
         if (data_resultRDY) begin
            res_q <= lo;
            exc_q <= exc_now;
         end
      end
   end

   // During the DONE cycle the fresh result is shown directly; afterwards the held copy.
   assign data_result    = data_resultRDY ? lo      : res_q;
   assign data_exception = data_resultRDY ? exc_now : exc_q;

`ifdef MULT_SEQ_HI_EN
   logic [31:0] hi_q;
   always_ff @(posedge clock) begin
      if (!reset_n)            hi_q <= '0;
      else if (data_resultRDY) hi_q <= hi;
   end
   assign data_result_hi = data_resultRDY ? hi : hi_q;
`endif

endmodule
